// File: rtl/lsu_mem_if.sv
// Load/store unit for RV32I: runs one req/ack data-memory transaction per
// load or store, stalls the pipeline while it is in flight, and returns
// lane-aligned, sign/zero-extended load data with a one-cycle done pulse.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    // Last counter value before the request is abandoned; unused when TIMEOUT is 0.
    localparam logic [31:0] TmoLast = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_e      r_state, w_state_next;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_func3;
    logic [1:0]  r_off;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;

    logic        w_start;
    logic        w_err;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;

    assign w_start   = mem_read_i | mem_write_i;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TmoLast);

    // Request legality: conflicting op, unsupported width, or misalignment.
    always_comb begin
        w_err = 1'b0;
        if (mem_read_i && mem_write_i) begin
            w_err = 1'b1;
        end else if (mem_read_i) begin
            case (func3_i)
                3'b000, 3'b100: w_err = 1'b0;
                3'b001, 3'b101: w_err = addr_i[0];
                3'b010:         w_err = |addr_i[1:0];
                default:        w_err = 1'b1;
            endcase
        end else begin
            case (func3_i)
                3'b000:  w_err = 1'b0;
                3'b001:  w_err = addr_i[0];
                3'b010:  w_err = |addr_i[1:0];
                default: w_err = 1'b1;
            endcase
        end
    end

    // Byte enables and lane-replicated store data from width and offset.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (func3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << addr_i[1:0];
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_i;
            end
        endcase
    end

    // Shift the addressed lane down and extend according to the captured func3.
    always_comb begin
        w_lane = dmem_rdata_i >> {r_off, 3'b000};
        case (r_func3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; illegal requests skip the bus and report straight away.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = w_err ? StResp : StReq;
                end
            end
            StReq: begin
                if (dmem_ack_i || w_timeout) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state; stall is raised combinationally on a new request.
    always_comb begin
        stall_o    = ~rst & (((r_state == StIdle) & w_start) | (r_state == StReq));
        dmem_req_o = (r_state == StReq);
        done_o     = (r_state == StResp);
        err_o      = (r_state == StResp) & r_err;
    end

    // Transaction datapath: capture request, count wait cycles, capture load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_func3 <= 3'd0;
            r_off   <= 2'd0;
            r_cnt   <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_err <= w_err;
                        r_cnt <= 32'd0;
                        if (!w_err) begin
                            r_we    <= mem_write_i;
                            r_addr  <= {addr_i[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_func3 <= func3_i;
                            r_off   <= addr_i[1:0];
                        end
                    end
                end
                StReq: begin
                    if (dmem_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata_o      = r_rdata;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

endmodule
